// File: rtl/password_store.sv
// Lock password store: combinational digit read port for the validator plus a
// guarded, shadow-buffered "set new password" session committed atomically.
module password_store #(
    parameter logic [15:0] DEFAULT_PW = 16'h0000,
    parameter int          TIMEOUT    = 1000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       unlocked,
    input  logic       set_req,
    input  logic       abort,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic [1:0] address,
    output logic [3:0] data,
    output logic       setting,
    output logic       set_done,
    output logic       set_error,
    output logic [1:0] dbgState
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   pw_q, pw_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            pw_q     <= DEFAULT_PW;
            shadow_q <= 16'h0000;
            idx_q    <= 2'd0;
            timer_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pw_q     <= pw_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pw_d     = pw_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (set_req) begin
                    if (unlocked) begin
                        state_d = ENTRY;
                        idx_d   = 2'd0;
                        timer_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ENTRY: begin
                // Cancel conditions outrank digit acceptance in the same cycle.
                if (abort || !unlocked) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (digit_valid) begin
                    if (digit > 4'd9) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        shadow_d[{idx_q, 2'b00} +: 4] = digit;
                        timer_d = '0;
                        if (idx_q == 2'd3) begin
                            state_d = COMMIT;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end else if (timer_q == TMAX) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            COMMIT: begin
                pw_d    = shadow_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data      = pw_q[{address, 2'b00} +: 4];
    assign setting   = (state_q == ENTRY);
    assign set_done  = done_q;
    assign set_error = err_q;
    assign dbgState  = state_q;

endmodule

// File: tb/tb_password_store.sv
// Directed bench for password_store: table of entry sessions plus hand-written
// sequences for timeout, locked request, idle strobes and reset mid-entry.
module tb_password_store;

    logic       CLK = 1'b0;
    logic       RST;
    logic       unlocked;
    logic       set_req;
    logic       abort;
    logic       digit_valid;
    logic [3:0] digit;
    logic [1:0] address;
    logic [3:0] data;
    logic       setting;
    logic       set_done;
    logic       set_error;
    logic [1:0] dbgState;

    int total = 0;
    int bad   = 0;

    password_store #(
        .DEFAULT_PW(16'h1234),
        .TIMEOUT   (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .unlocked   (unlocked),
        .set_req    (set_req),
        .abort      (abort),
        .digit_valid(digit_valid),
        .digit      (digit),
        .address    (address),
        .data       (data),
        .setting    (setting),
        .set_done   (set_done),
        .set_error  (set_error),
        .dbgState   (dbgState)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] digs;     // digit 0 in [3:0]
        int          n;        // digits driven
        logic        ab;       // abort together with the last digit
        logic        exp_done;
        logic        exp_err;
        logic [15:0] exp_pw;
    } sess_t;

    sess_t sess[4];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_pw(input string name, input logic [15:0] exp);
        logic [3:0] nib;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            nib = exp[a*4 +: 4];
            check($sformatf("%s_addr%0d", name, a), {12'h0, data}, {12'h0, nib});
        end
    endtask

    task automatic start_session();
        unlocked = 1'b1;
        set_req  = 1'b1;
        step();
        set_req = 1'b0;
        check("session_entered", {14'h0, dbgState}, 16'd1);
    endtask

    initial begin
        logic [15:0] cur_pw;
        logic [3:0]  nib;

        RST = 1'b1; unlocked = 1'b0; set_req = 1'b0; abort = 1'b0;
        digit_valid = 1'b0; digit = 4'h0; address = 2'd0;

        sess[0] = '{digs: 16'h7905, n: 4, ab: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_pw: 16'h7905};
        sess[1] = '{digs: 16'h0321, n: 3, ab: 1'b1, exp_done: 1'b0, exp_err: 1'b1, exp_pw: 16'h7905};
        sess[2] = '{digs: 16'h0B66, n: 3, ab: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_pw: 16'h7905};
        sess[3] = '{digs: 16'h3218, n: 4, ab: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_pw: 16'h3218};

        // Reset state and default password sweep
        step(); step();
        RST = 1'b0;
        check("rst_state", {14'h0, dbgState}, 16'd0);
        check("rst_setting", {15'h0, setting}, 16'd0);
        check("rst_done", {15'h0, set_done}, 16'd0);
        check("rst_error", {15'h0, set_error}, 16'd0);
        check_pw("rst_pw", 16'h1234);
        cur_pw = 16'h1234;

        // Table of entry sessions
        for (int s = 0; s < 4; s++) begin
            start_session();
            for (int i = 0; i < sess[s].n; i++) begin
                digit_valid = 1'b1;
                digit       = sess[s].digs[i*4 +: 4];
                abort       = sess[s].ab && (i == sess[s].n - 1);
                step();
            end
            digit_valid = 1'b0; abort = 1'b0;
            check($sformatf("s%0d_done", s), {15'h0, set_done}, {15'h0, sess[s].exp_done});
            check($sformatf("s%0d_error", s), {15'h0, set_error}, {15'h0, sess[s].exp_err});
            check($sformatf("s%0d_state", s), {14'h0, dbgState},
                  sess[s].exp_done ? 16'd2 : 16'd0);
            if (sess[s].exp_done) begin
                // Committed digits are not yet visible during COMMIT
                address = 2'd0;
                #1;
                nib = cur_pw[3:0];
                check($sformatf("s%0d_commit_old", s), {12'h0, data}, {12'h0, nib});
            end
            step();
            check($sformatf("s%0d_done_off", s), {15'h0, set_done}, 16'd0);
            check($sformatf("s%0d_error_off", s), {15'h0, set_error}, 16'd0);
            check($sformatf("s%0d_idle", s), {14'h0, dbgState}, 16'd0);
            check_pw($sformatf("s%0d_pw", s), sess[s].exp_pw);
            cur_pw = sess[s].exp_pw;
        end

        // Strobes in IDLE are ignored
        digit_valid = 1'b1; digit = 4'h9; abort = 1'b1;
        step();
        digit_valid = 1'b0; abort = 1'b0;
        check("idle_strobe_state", {14'h0, dbgState}, 16'd0);
        check("idle_strobe_err", {15'h0, set_error}, 16'd0);
        check_pw("idle_strobe_pw", cur_pw);

        // Timeout: error exactly 8 cycles after the last accepted digit
        start_session();
        digit_valid = 1'b1; digit = 4'h2;
        step();
        digit_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("to_err_k%0d", k), {15'h0, set_error}, (k == 8) ? 16'd1 : 16'd0);
            check($sformatf("to_setting_k%0d", k), {15'h0, setting}, (k == 8) ? 16'd0 : 16'd1);
        end
        step();
        check("to_err_off", {15'h0, set_error}, 16'd0);
        check_pw("to_pw", cur_pw);

        // set_req while locked
        unlocked = 1'b0; set_req = 1'b1;
        step();
        set_req = 1'b0;
        check("lock_err", {15'h0, set_error}, 16'd1);
        check("lock_state", {14'h0, dbgState}, 16'd0);
        check("lock_setting", {15'h0, setting}, 16'd0);
        step();
        check("lock_err_off", {15'h0, set_error}, 16'd0);

        // Losing unlock mid-entry cancels
        start_session();
        unlocked = 1'b0;
        step();
        check("unlk_err", {15'h0, set_error}, 16'd1);
        check("unlk_state", {14'h0, dbgState}, 16'd0);

        // Reset mid-entry after 3 digits
        start_session();
        for (int i = 0; i < 3; i++) begin
            digit_valid = 1'b1; digit = 4'(i + 5);
            step();
        end
        digit_valid = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("rst_mid_state", {14'h0, dbgState}, 16'd0);
        check("rst_mid_done", {15'h0, set_done}, 16'd0);
        check("rst_mid_error", {15'h0, set_error}, 16'd0);
        check_pw("rst_mid_pw", 16'h1234);
        step();
        check("rst_mid_done2", {15'h0, set_done}, 16'd0);
        check("rst_mid_error2", {15'h0, set_error}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
